// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, issue FSM state type and command record for the ALU issue path
package alu_pkg;

   localparam int ALU_WIDTH = 4;
   localparam int ALU_OP_W  = 3;

   localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b010;
   localparam logic [ALU_OP_W-1:0] OP_AND = 3'b011;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b100;
   localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b101;
   localparam logic [ALU_OP_W-1:0] OP_LT  = 3'b110;
   localparam logic [ALU_OP_W-1:0] OP_EQ  = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } issue_state_t;

   typedef struct packed {
      logic [ALU_OP_W-1:0]  op;
      logic [ALU_WIDTH-1:0] a;
      logic [ALU_WIDTH-1:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, ALU operand/result and response signals of the issue controller
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [OP_W-1:0]  cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;

   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_flag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_flag;

   // master is the issue controller; slave is the surrounding command source, ALU and consumer
   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b,
      output cmd_ready,
      output alu_op, alu_a, alu_b,
      input  alu_result, alu_flag,
      output rsp_valid, rsp_result, rsp_flag,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b,
      input  cmd_ready,
      input  alu_op, alu_a, alu_b,
      output alu_result, alu_flag,
      input  rsp_valid, rsp_result, rsp_flag,
      output rsp_ready
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous FIFO for pending ALU commands, extra pointer MSB tells full from empty
module alu_cmd_fifo #(
   parameter int DATA_W = 11,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - buffers ALU commands, issues one at a time, waits ALU_LAT, returns responses in order
// Optional ALU_ISSUE_STATS_EN adds stat_issued (wrapping) and stat_stall (saturating) counters.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int OP_W    = ALU_OP_W,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.master  bus,
   output logic              busy
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [7:0]        stat_issued,
   output logic [7:0]        stat_stall
`endif
);
   localparam int CMD_W = OP_W + 2 * WIDTH;
   localparam int CNT_W = 3;

   issue_state_t     state, state_nxt;
   logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
   logic             issue;
   logic             capture;
   logic             rsp_clear;
   logic             out_of_reset;

   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic [CMD_W-1:0] fifo_din;
   logic [CMD_W-1:0] fifo_dout;

   logic [OP_W-1:0]  alu_op_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_flag_q;

   // held low until the first clock after reset so upstream never sees ready during reset
   assign bus.cmd_ready = out_of_reset && !fifo_full;
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign fifo_din      = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
   assign busy          = !fifo_empty || (state != IDLE);

   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flag   = rsp_flag_q;

   alu_cmd_fifo #(
      .DATA_W (CMD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (fifo_din),
      .pop   (issue),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      issue       = 1'b0;
      capture     = 1'b0;
      rsp_clear   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               issue       = 1'b1;
               lat_cnt_nxt = CNT_W'(ALU_LAT);
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt != '0) lat_cnt_nxt = lat_cnt - 1'b1;
            if (lat_cnt <= CNT_W'(1)) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            capture   = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (bus.rsp_ready) begin
               rsp_clear = 1'b1;
               // back-to-back issue keeps the ALU busy without an IDLE bubble
               if (!fifo_empty) begin
                  issue       = 1'b1;
                  lat_cnt_nxt = CNT_W'(ALU_LAT);
                  state_nxt   = WAIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lat_cnt      <= '0;
         out_of_reset <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flag_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         lat_cnt      <= lat_cnt_nxt;
         out_of_reset <= 1'b1;
         if (issue) begin
            alu_op_q <= fifo_dout[CMD_W-1 -: OP_W];
            alu_a_q  <= fifo_dout[2*WIDTH-1 -: WIDTH];
            alu_b_q  <= fifo_dout[WIDTH-1:0];
         end
         if (capture) begin
            rsp_result_q <= bus.alu_result;
            rsp_flag_q   <= bus.alu_flag;
            rsp_valid_q  <= 1'b1;
         end else if (rsp_clear) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue) stat_issued <= stat_issued + 8'd1;
         if (rsp_valid_q && !bus.rsp_ready && (stat_stall != 8'hFF))
            stat_stall <= stat_stall + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed vector bench for alu_issue_ctrl with registered ALU models of latency 1 and 2
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   logic busy1;
   logic busy2;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

`ifdef ALU_ISSUE_STATS_EN
   logic [7:0] stat_issued1, stat_stall1, stat_issued2, stat_stall2;
`endif

   alu_issue_ctrl_if #(.WIDTH(4), .OP_W(3)) ifc1 ();
   alu_issue_ctrl_if #(.WIDTH(4), .OP_W(3)) ifc2 ();

   alu_issue_ctrl #(.WIDTH(4), .OP_W(3), .DEPTH(4), .ALU_LAT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc1),
      .busy  (busy1)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .stat_issued (stat_issued1),
      .stat_stall  (stat_stall1)
`endif
   );

   alu_issue_ctrl #(.WIDTH(4), .OP_W(3), .DEPTH(4), .ALU_LAT(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc2),
      .busy  (busy2)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .stat_issued (stat_issued2),
      .stat_stall  (stat_stall2)
`endif
   );

   // reference ALU: {flag, result}
   function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_NOT:  return {1'b0, ~a};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_LT:   return {(a < b), 4'h0};
         default: return {(a == b), 4'h0};
      endcase
   endfunction

   logic [4:0] m1, m2a, m2b;
   always @(posedge clk) begin
      m1  <= alu_f(ifc1.alu_op, ifc1.alu_a, ifc1.alu_b);
      m2a <= alu_f(ifc2.alu_op, ifc2.alu_a, ifc2.alu_b);
      m2b <= m2a;
   end
   assign ifc1.alu_result = m1[3:0];
   assign ifc1.alu_flag   = m1[4];
   assign ifc2.alu_result = m2b[3:0];
   assign ifc2.alu_flag   = m2b[4];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge right after the accepting posedge
   task automatic push1(input alu_cmd_t c);
      int t = 0;
      ifc1.cmd_valid = 1'b1;
      ifc1.cmd_op    = c.op;
      ifc1.cmd_a     = c.a;
      ifc1.cmd_b     = c.b;
      while (!ifc1.cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("cmd_accept", ifc1.cmd_ready, 1);
      @(negedge clk);
      ifc1.cmd_valid = 1'b0;
   endtask

   typedef struct {
      alu_cmd_t   cmd;
      logic [3:0] res;
      logic       flag;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   logic [3:0] exp_q [$];
   int         t0, n, k, seen;
   int         rsp_cyc [3];
   alu_cmd_t   c;

   initial begin
      vecs[0] = '{cmd: '{OP_ADD, 4'h3, 4'h4}, res: 4'h7, flag: 1'b0};
      vecs[1] = '{cmd: '{OP_SUB, 4'h2, 4'h5}, res: 4'hD, flag: 1'b1};
      vecs[2] = '{cmd: '{OP_ADD, 4'h9, 4'h8}, res: 4'h1, flag: 1'b1};
      vecs[3] = '{cmd: '{OP_NOT, 4'h5, 4'h0}, res: 4'hA, flag: 1'b0};
      vecs[4] = '{cmd: '{OP_AND, 4'hC, 4'hA}, res: 4'h8, flag: 1'b0};
      vecs[5] = '{cmd: '{OP_OR,  4'hC, 4'h3}, res: 4'hF, flag: 1'b0};
      vecs[6] = '{cmd: '{OP_XOR, 4'hF, 4'h5}, res: 4'hA, flag: 1'b0};
      vecs[7] = '{cmd: '{OP_LT,  4'h3, 4'h9}, res: 4'h0, flag: 1'b1};
      vecs[8] = '{cmd: '{OP_EQ,  4'h6, 4'h7}, res: 4'h0, flag: 1'b0};
      vecs[9] = '{cmd: '{OP_SUB, 4'h0, 4'h1}, res: 4'hF, flag: 1'b1};

      rst_n = 1'b0;
      ifc1.cmd_valid = 1'b0; ifc1.cmd_op = '0; ifc1.cmd_a = '0; ifc1.cmd_b = '0; ifc1.rsp_ready = 1'b1;
      ifc2.cmd_valid = 1'b0; ifc2.cmd_op = '0; ifc2.cmd_a = '0; ifc2.cmd_b = '0; ifc2.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("reset_cmd_ready", ifc1.cmd_ready, 0);
      check("reset_rsp_valid", ifc1.rsp_valid, 0);
      check("reset_rsp_result", ifc1.rsp_result, 0);
      check("reset_alu_op", ifc1.alu_op, 0);
      check("reset_busy", busy1, 0);
      rst_n = 1'b1;
      #1 check("cmd_ready_before_first_edge", ifc1.cmd_ready, 0);
      @(negedge clk);
      check("cmd_ready_after_reset", ifc1.cmd_ready, 1);

      // single-command vectors on the latency-1 instance
      for (int i = 0; i < NV; i++) begin
         push1(vecs[i].cmd);
         t0 = cyc - 1;
         n  = 0;
         while (!ifc1.rsp_valid && n < 20) begin
            if (cyc >= t0 + 2) check("alu_op_stable", ifc1.alu_op, vecs[i].cmd.op);
            @(negedge clk);
            n++;
         end
         check("rsp_latency", cyc - t0, 4);
         check("rsp_result", ifc1.rsp_result, vecs[i].res);
         check("rsp_flag", ifc1.rsp_flag, vecs[i].flag);
         check("alu_a_hold", ifc1.alu_a, vecs[i].cmd.a);
         @(negedge clk);
         check("rsp_valid_drop", ifc1.rsp_valid, 0);
         check("busy_idle", busy1, 0);
      end

      // downstream stall: one held in HOLD, four buffered, sixth refused
      ifc1.rsp_ready = 1'b0;
      exp_q.delete();
      for (int i = 1; i <= 5; i++) begin
         c = '{OP_ADD, 4'(i), 4'(i)};
         push1(c);
         exp_q.push_back(4'(2 * i));
      end
      ifc1.cmd_valid = 1'b1;
      ifc1.cmd_op = OP_ADD; ifc1.cmd_a = 4'h7; ifc1.cmd_b = 4'h7;
      repeat (3) @(negedge clk);
      check("full_cmd_ready", ifc1.cmd_ready, 0);
      check("hold_rsp_valid", ifc1.rsp_valid, 1);
      check("hold_rsp_result", ifc1.rsp_result, 4'h2);
      check("busy_stalled", busy1, 1);
      ifc1.cmd_valid = 1'b0;
      ifc1.rsp_ready = 1'b1;
      k = 0; n = 0;
      while (k < 5 && n < 100) begin
         if (ifc1.rsp_valid) begin
            check("stall_rsp_order", ifc1.rsp_result, exp_q[k]);
            k++;
         end
         @(negedge clk);
         n++;
      end
      check("stall_rsp_count", k, 5);
      n = 0;
      while (busy1 && n < 20) begin @(negedge clk); n++; end
      check("stall_drain_idle", busy1, 0);

      // back-to-back issue on the latency-2 instance
      for (int j = 0; j < 3; j++) begin
         ifc2.cmd_valid = 1'b1;
         case (j)
            0:       begin ifc2.cmd_op = OP_ADD; ifc2.cmd_a = 4'h1; ifc2.cmd_b = 4'h2; end
            1:       begin ifc2.cmd_op = OP_SUB; ifc2.cmd_a = 4'h9; ifc2.cmd_b = 4'h4; end
            default: begin ifc2.cmd_op = OP_OR;  ifc2.cmd_a = 4'h8; ifc2.cmd_b = 4'h1; end
         endcase
         check("b2b_cmd_ready", ifc2.cmd_ready, 1);
         @(negedge clk);
      end
      ifc2.cmd_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(4'h3); exp_q.push_back(4'h5); exp_q.push_back(4'h9);
      k = 0; n = 0;
      while (k < 3 && n < 100) begin
         if (ifc2.rsp_valid) begin
            check("b2b_rsp_result", ifc2.rsp_result, exp_q[k]);
            rsp_cyc[k] = cyc;
            k++;
         end
         @(negedge clk);
         n++;
      end
      check("b2b_rsp_count", k, 3);
      check("b2b_gap_1", rsp_cyc[1] - rsp_cyc[0], 4);
      check("b2b_gap_2", rsp_cyc[2] - rsp_cyc[1], 4);

      // reset mid-operation: dut2 in WAIT with two queued, dut1 holding a response
      ifc1.rsp_ready = 1'b0;
      c = '{OP_ADD, 4'h2, 4'h3};
      push1(c);
      ifc2.cmd_valid = 1'b1;
      ifc2.cmd_op = OP_ADD; ifc2.cmd_a = 4'h5; ifc2.cmd_b = 4'h6;
      @(negedge clk);
      ifc2.cmd_op = OP_SUB; ifc2.cmd_a = 4'h3; ifc2.cmd_b = 4'h1;
      @(negedge clk);
      ifc2.cmd_op = OP_AND; ifc2.cmd_a = 4'hF; ifc2.cmd_b = 4'hF;
      @(negedge clk);
      ifc2.cmd_valid = 1'b0;
      check("pre_reset_busy", busy2, 1);
      check("pre_reset_alu_a", ifc2.alu_a, 4'h5);
      check("pre_reset_hold_valid", ifc1.rsp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rsp_valid", ifc1.rsp_valid, 0);
      check("rst_busy", busy2, 0);
      check("rst_alu_op", ifc2.alu_op, 0);
      check("rst_alu_a", ifc2.alu_a, 0);
      check("rst_alu_b", ifc2.alu_b, 0);
      check("rst_cmd_ready", ifc2.cmd_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ifc1.rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_release_cmd_ready", ifc2.cmd_ready, 1);
      seen = 0;
      repeat (12) begin
         if (ifc1.rsp_valid || ifc2.rsp_valid || busy2) seen++;
         @(negedge clk);
      end
      check("no_stale_rsp", seen, 0);

`ifdef ALU_ISSUE_STATS_EN
      ifc1.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c = '{OP_XOR, 4'(i), 4'hF};
         push1(c);
      end
      n = 0;
      while (!ifc1.rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("stats_first_valid", ifc1.rsp_valid, 1);
      repeat (5) @(negedge clk);
      ifc1.rsp_ready = 1'b1;
      n = 0;
      while (busy1 && n < 50) begin @(negedge clk); n++; end
      check("stats_idle", busy1, 0);
      check("stat_issued", stat_issued1, 3);
      check("stat_stall", stat_stall1, 5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester side of the 4-bit ALU operand/result interface.
- Accepts ALU commands (op, a, b) from upstream over valid/ready and buffers them in a small FIFO.
- Drives one command at a time onto the ALU's op/a/b inputs, waits out the ALU's registered latency, then captures result and flag.
- Returns each response downstream over valid/ready, in order. Sits between the keypad/switch command front-end and the display/result consumer.

Parameters:
- WIDTH, 4, operand and result width.
- OP_W, 3, opcode width.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- ALU_LAT, 1, cycles from ALU input change to a valid ALU result/flag; range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  OP_W  opcode.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- alu_op  out  OP_W  to ALU op.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_result  in  WIDTH  ALU result.
- alu_flag  in  1  ALU single-bit out (carry/compare).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream ready.
- rsp_result  out  WIDTH  captured result.
- rsp_flag  out  1  captured flag.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, latency counter 0. cmd_ready = 1 one cycle after rst_n deasserts.
- FIFO push on cmd_valid && cmd_ready. cmd_ready = !full. Pointers are log2(DEPTH)+1 bits; wrap is modulo DEPTH. Full = MSBs differ and low bits equal.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and register it into alu_op/a/b; counter = ALU_LAT; go to WAIT.
  - WAIT: decrement counter; at 1 go to CAPTURE. alu_* stay stable throughout.
  - CAPTURE: latch alu_result/alu_flag into rsp_result/rsp_flag; assert rsp_valid; go to HOLD.
  - HOLD: hold rsp_* stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid. If the FIFO is non-empty in that same cycle, pop and go to WAIT (back-to-back issue); otherwise go to IDLE.
- Latency: command accepted at cycle N with FIFO empty and FSM idle → rsp_valid at N+ALU_LAT+3.
- Throughput with rsp_ready held high: one response per ALU_LAT+2 cycles.
- alu_* retain the last issued command when idle. No combinational path from alu_result to rsp_*.
- Simultaneous push and pop on a full FIFO: push is refused (cmd_ready = 0). Pop proceeds.
- Push into an empty FIFO while IDLE: the entry is visible to the FSM the next cycle; no bypass.
- Reset mid-operation: FIFO flushed, in-flight command discarded, rsp_valid drops asynchronously, alu_* return to 0.
- Opcode is passed through unmodified; no arithmetic is performed in this block.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued (8 bits, increments per ALU issue, wraps at 255→0) and stat_stall (8 bits, increments each cycle rsp_valid && !rsp_ready, saturates at 255). Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_ADD=3'b000, OP_SUB=3'b001, OP_NOT=3'b010, OP_AND=3'b011, OP_OR=3'b100, OP_XOR=3'b101, OP_LT=3'b110, OP_EQ=3'b111;
  - the FSM state type {IDLE, WAIT, CAPTURE, HOLD};
  - a packed command struct {op, a, b}.
- One sub-module, alu_cmd_fifo: parameterised synchronous FIFO with push, pop, full, empty.

Test Plan:
- Single ADD, a=3, b=4, ALU model returning 7 after ALU_LAT=1, rsp_ready=1 → rsp_valid at cycle N+4, rsp_result=4'h7, rsp_flag=0, busy low the next cycle.
- SUB a=2, b=5 with model result 4'hD, flag=1 → rsp_result=4'hD, rsp_flag=1. alu_op=3'b001 stable across WAIT.
- rsp_ready=0, push 6 commands → 1 issued and held in HOLD, 4 buffered, cmd_ready=0 on the 6th. Release rsp_ready → 5 responses return in push order.
- Back-to-back: 3 commands, rsp_ready=1, ALU_LAT=2 → responses exactly 4 cycles apart.
- rst_n pulsed low during WAIT with 2 commands queued → rsp_valid=0, busy=0, alu_*=0, no stale response after release.
- With ALU_ISSUE_STATS_EN: 3 commands, rsp_ready low for 5 cycles on the first → stat_issued=3, stat_stall=5.
